term_tx_arbiter: RTL and testbench

//  Shares the single terminal byte sink (UART transmitter) between N_REQ byte sources.

---
 rtl/term_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_term_tx_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/term_tx_arbiter.sv
// Shares one terminal byte sink between N_REQ byte sources with per-message grant locking.
// Round-robin winner selection in IDLE; a locked owner is dropped after TIMEOUT idle HOLD cycles.
module term_tx_arbiter #(
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = 1024,
   parameter int TW      = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [8*N_REQ-1:0] i_req_byte,
   input  logic [N_REQ-1:0]   i_req_v,
   input  logic [N_REQ-1:0]   i_req_last,
   output logic [N_REQ-1:0]   o_req_done,
   output logic [N_REQ-1:0]   o_grant,
   output logic               o_timeout,
   output logic [7:0]         o_byte,
   output logic               o_byte_v,
   input  logic               i_byte_done
);

   // state  | meaning
   // IDLE   | no owner; pick round-robin winner among valid requesters
   // SEND   | o_byte presented to sink, waiting for i_byte_done
   // ACK    | o_req_done pulse to owner; requester inputs ignored
   // HOLD   | grant locked mid-message; wait for owner's next byte or timeout
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_ACK, S_HOLD} state_t;

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t            state, state_nxt;
   logic [IW-1:0]     g, rr_ptr, win_idx, src, g_next;
   logic              win_found;
   logic [TW-1:0]     cnt;
   logic              last_q;
   logic [7:0]        byte_q;
   logic [7:0]        byte_sel;
   logic              last_sel;
   logic              load;
   logic              tmo;
   logic [N_REQ-1:0]  g_onehot;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      // Descending scan so the lowest offset from rr_ptr is the final winner.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (i_req_v[IW'((int'(rr_ptr) + i) % N_REQ)]) begin
            win_found = 1'b1;
            win_idx   = IW'((int'(rr_ptr) + i) % N_REQ);
         end
      end
   end

   assign src = (state == S_IDLE) ? win_idx : g;

   always_comb begin
      byte_sel = 8'h00;
      last_sel = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (IW'(k) == src) begin
            byte_sel = i_req_byte[8*k +: 8];
            last_sel = i_req_last[k];
         end
      end
   end

   assign g_next   = (g == IW'(N_REQ - 1)) ? '0 : g + IW'(1);
   assign g_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << g;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      tmo       = 1'b0;
      case (state)
         S_IDLE: if (win_found) begin
            state_nxt = S_SEND;
            load      = 1'b1;
         end
         S_SEND: if (i_byte_done) state_nxt = S_ACK;
         S_ACK:  state_nxt = last_q ? S_IDLE : S_HOLD;
         S_HOLD: begin
            if (i_req_v[g]) begin
               state_nxt = S_SEND;
               load      = 1'b1;
            end else if (cnt == TW'(TIMEOUT - 1)) begin
               state_nxt = S_IDLE;
               tmo       = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_byte_v   = (state == S_SEND);
      o_grant    = (state != S_IDLE) ? g_onehot : '0;
      o_req_done = (state == S_ACK) ? g_onehot : '0;
      o_timeout  = tmo;
      o_byte     = byte_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g      <= '0;
         rr_ptr <= '0;
         cnt    <= '0;
         last_q <= 1'b0;
         byte_q <= 8'h00;
      end else begin
         if (load) begin
            byte_q <= byte_sel;
            last_q <= last_sel;
            if (state == S_IDLE) g <= win_idx;
         end
         if (state == S_ACK) begin
            cnt <= '0;
            if (last_q) rr_ptr <= g_next;
         end
         if (state == S_HOLD && !load && !tmo) cnt <= cnt + TW'(1);
         if (tmo) rr_ptr <= g_next;
      end
   end

endmodule

// File: tb/tb_term_tx_arbiter.sv
// Directed bench for term_tx_arbiter: cycle table for single/round-robin traffic,
// then hand sequences for message locking, timeout, spurious done and mid-send reset.
module tb_term_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] req_byte;
   logic [1:0]  req_v;
   logic [1:0]  req_last;
   logic [1:0]  req_done;
   logic [1:0]  grant;
   logic        timeout;
   logic [7:0]  obyte;
   logic        obyte_v;
   logic        byte_done;

   int cmp_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   term_tx_arbiter #(.N_REQ(2), .TIMEOUT(16), .TW(5)) dut (
      .clk(clk), .rst_n(rst_n), .i_req_byte(req_byte), .i_req_v(req_v),
      .i_req_last(req_last), .o_req_done(req_done), .o_grant(grant),
      .o_timeout(timeout), .o_byte(obyte), .o_byte_v(obyte_v), .i_byte_done(byte_done)
   );

   typedef struct {
      logic [1:0] v;
      logic [1:0] last;
      logic [7:0] b0;
      logic [7:0] b1;
      logic       done;
      logic [1:0] e_grant;
      logic       e_v;
      logic [7:0] e_byte;
      logic [1:0] e_rdone;
   } vec_t;

   vec_t tbl[14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sink model: wait for o_byte_v, take the byte, pulse done, report who got o_req_done.
   task automatic serve(output logic [7:0] b, output int who);
      int n;
      n   = 0;
      b   = 8'h00;
      who = -1;
      while (!obyte_v && n < 30) begin
         tick();
         n++;
      end
      if (!obyte_v) begin
         cmp_cnt++;
         err_cnt++;
         $display("FAIL serve_wait: o_byte_v never rose within 30 cycles at %0t", $time);
         return;
      end
      b         = obyte;
      byte_done = 1'b1;
      tick();
      byte_done = 1'b0;
      check("ack_byte_v_low", {31'd0, obyte_v}, 32'd0);
      if (req_done == 2'b01)      who = 0;
      else if (req_done == 2'b10) who = 1;
   endtask

   initial begin
      logic [7:0] b;
      int         who;
      int         n;

      tbl[0]  = '{2'b01, 2'b01, 8'h41, 8'h00, 1'b0, 2'b01, 1'b1, 8'h41, 2'b00};
      tbl[1]  = '{2'b01, 2'b01, 8'h41, 8'h00, 1'b0, 2'b01, 1'b1, 8'h41, 2'b00};
      tbl[2]  = '{2'b01, 2'b01, 8'h41, 8'h00, 1'b1, 2'b01, 1'b0, 8'h41, 2'b01};
      tbl[3]  = '{2'b00, 2'b00, 8'h41, 8'h00, 1'b0, 2'b00, 1'b0, 8'h41, 2'b00};
      tbl[4]  = '{2'b11, 2'b11, 8'h61, 8'h62, 1'b0, 2'b10, 1'b1, 8'h62, 2'b00};
      tbl[5]  = '{2'b11, 2'b11, 8'h61, 8'h62, 1'b1, 2'b10, 1'b0, 8'h62, 2'b10};
      tbl[6]  = '{2'b11, 2'b11, 8'h61, 8'h62, 1'b0, 2'b00, 1'b0, 8'h62, 2'b00};
      tbl[7]  = '{2'b11, 2'b11, 8'h61, 8'h62, 1'b0, 2'b01, 1'b1, 8'h61, 2'b00};
      tbl[8]  = '{2'b11, 2'b11, 8'h61, 8'h62, 1'b1, 2'b01, 1'b0, 8'h61, 2'b01};
      tbl[9]  = '{2'b11, 2'b11, 8'h61, 8'h62, 1'b0, 2'b00, 1'b0, 8'h61, 2'b00};
      tbl[10] = '{2'b11, 2'b11, 8'h61, 8'h62, 1'b0, 2'b10, 1'b1, 8'h62, 2'b00};
      tbl[11] = '{2'b00, 2'b00, 8'h61, 8'h62, 1'b1, 2'b10, 1'b0, 8'h62, 2'b10};
      tbl[12] = '{2'b00, 2'b00, 8'h61, 8'h62, 1'b0, 2'b00, 1'b0, 8'h62, 2'b00};
      tbl[13] = '{2'b00, 2'b00, 8'h61, 8'h62, 1'b1, 2'b00, 1'b0, 8'h62, 2'b00};

      rst_n     = 1'b0;
      req_byte  = 16'h0000;
      req_v     = 2'b00;
      req_last  = 2'b00;
      byte_done = 1'b0;
      #23;
      check("rst_grant",   {30'd0, grant},    32'd0);
      check("rst_byte_v",  {31'd0, obyte_v},  32'd0);
      check("rst_byte",    {24'd0, obyte},    32'd0);
      check("rst_done",    {30'd0, req_done}, 32'd0);
      check("rst_timeout", {31'd0, timeout},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) begin
         req_v     = tbl[i].v;
         req_last  = tbl[i].last;
         req_byte  = {tbl[i].b1, tbl[i].b0};
         byte_done = tbl[i].done;
         tick();
         check($sformatf("tbl%0d_grant", i),   {30'd0, grant},    {30'd0, tbl[i].e_grant});
         check($sformatf("tbl%0d_byte_v", i),  {31'd0, obyte_v},  {31'd0, tbl[i].e_v});
         check($sformatf("tbl%0d_byte", i),    {24'd0, obyte},    {24'd0, tbl[i].e_byte});
         check($sformatf("tbl%0d_done", i),    {30'd0, req_done}, {30'd0, tbl[i].e_rdone});
         check($sformatf("tbl%0d_timeout", i), {31'd0, timeout},  32'd0);
      end
      byte_done = 1'b0;
      req_v     = 2'b00;

      // Message lock: req0 ESC [ H must not be interleaved with req1's space.
      req_v    = 2'b11;
      req_last = 2'b10;
      req_byte = {8'h20, 8'h1b};
      serve(b, who);
      check("lock_b0", {24'd0, b}, 32'h1b);
      check("lock_w0", who, 0);
      req_byte[7:0] = 8'h5b;
      serve(b, who);
      check("lock_b1", {24'd0, b}, 32'h5b);
      check("lock_w1", who, 0);
      req_byte[7:0] = 8'h48;
      req_last      = 2'b11;
      serve(b, who);
      check("lock_b2", {24'd0, b}, 32'h48);
      check("lock_w2", who, 0);
      req_v = 2'b10;
      serve(b, who);
      check("lock_b3", {24'd0, b}, 32'h20);
      check("lock_w3", who, 1);
      req_v = 2'b00;

      // Timeout: req0 leaves a message open; req1 waits behind the lock.
      req_v    = 2'b01;
      req_last = 2'b00;
      req_byte = {8'h00, 8'h1b};
      serve(b, who);
      check("tmo_b0", {24'd0, b}, 32'h1b);
      check("tmo_w0", who, 0);
      req_v    = 2'b10;
      req_last = 2'b10;
      req_byte = {8'h55, 8'h00};
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (timeout) break;
      end
      check("tmo_delay", n, 16);
      check("tmo_grant_held", {30'd0, grant}, 32'd1);
      tick();
      check("tmo_pulse_end", {31'd0, timeout}, 32'd0);
      check("tmo_grant_drop", {30'd0, grant},  32'd0);
      tick();
      check("tmo_next_grant", {30'd0, grant},   32'd2);
      check("tmo_next_v",     {31'd0, obyte_v}, 32'd1);
      check("tmo_next_byte",  {24'd0, obyte},   32'h55);
      serve(b, who);
      check("tmo_w1", who, 1);
      req_v = 2'b00;

      // Spurious done while HOLD must be ignored.
      req_v    = 2'b01;
      req_last = 2'b00;
      req_byte = {8'h00, 8'h1b};
      serve(b, who);
      check("sp_w0", who, 0);
      req_v = 2'b00;
      tick();
      tick();
      byte_done = 1'b1;
      tick();
      byte_done = 1'b0;
      check("sp_done",  {30'd0, req_done}, 32'd0);
      check("sp_grant", {30'd0, grant},    32'd1);
      check("sp_v",     {31'd0, obyte_v},  32'd0);
      req_v    = 2'b01;
      req_last = 2'b01;
      req_byte = {8'h00, 8'h48};
      serve(b, who);
      check("sp_b1", {24'd0, b}, 32'h48);
      check("sp_w1", who, 0);
      req_v = 2'b00;
      tick();
      check("sp_idle_grant", {30'd0, grant}, 32'd0);

      // Mid-send reset drops o_byte_v asynchronously; afterwards rr_ptr is 0 again.
      req_v    = 2'b10;
      req_last = 2'b10;
      req_byte = {8'h77, 8'h00};
      tick();
      check("mr_send_v", {31'd0, obyte_v}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_v_low",  {31'd0, obyte_v}, 32'd0);
      check("mr_grant",  {30'd0, grant},   32'd0);
      check("mr_byte",   {24'd0, obyte},   32'd0);
      req_v    = 2'b11;
      req_last = 2'b11;
      req_byte = {8'h5a, 8'ha5};
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("mr_after_grant", {30'd0, grant}, 32'd1);
      check("mr_after_byte",  {24'd0, obyte}, 32'ha5);
      req_v = 2'b00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
